platform_refresher: RTL



---
 rtl/jump_pkg.sv | 33 +++
 rtl/lfsr16.sv | 22 ++
 rtl/platform_refresher.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/jump_pkg.sv
// Shared game-side types and constants.
// Game-state encodings, screen geometry, platform record.
package jump_pkg;

  localparam logic [2:0] GS_MENU    = 3'b000;
  localparam logic [2:0] GS_GAME    = 3'b001;
  localparam logic [2:0] GS_PAUSE   = 3'b010;
  localparam logic [2:0] GS_REFRESH = 3'b011;

  localparam int SCREEN_H = 480;
  localparam int SCREEN_W = 640;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } plat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARMED,
    ST_SCROLL,
    ST_DONE
  } ref_state_t;

  // Platform x drawn from the low LFSR bits: 0..511.
  function automatic logic [9:0] lfsr_x(
    input logic [15:0] s
  );
    return {1'b0, s[8:0]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Free-running: advances on every clock.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clock,
  input  logic        Reset_n,
  output logic [15:0] state
);

  logic fb;

  assign fb = state[15] ^ state[13]
            ^ state[12] ^ state[10];

  // Shift left, feedback into bit 0.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= SEED;
    else          state <= {state[14:0], fb};
  end

endmodule

// File: rtl/platform_refresher.sv
// Platform table owner: seeds, requests refresh,
// scrolls and recycles platforms, then hands back.
module platform_refresher #(
  parameter int          NUM_PLAT    = 8,
  parameter int          SCREEN_H    = jump_pkg::SCREEN_H,
  parameter int          THRESH      = 160,
  parameter int          SCROLL_SPD  = 4,
  parameter int          SCROLL_DIST = 120,
  parameter int          PLAT_STEP   = 60,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  input  logic                        frame_tick,
  input  logic [2:0]                  outstate,
  input  logic                        loadplat,
  input  logic [9:0]                  doodle_y,
  input  logic [$clog2(NUM_PLAT)-1:0] rd_idx,
  output logic [9:0]                  rd_x,
  output logic [9:0]                  rd_y,
  output logic                        refresh_en,
  output logic                        trigger,
  output logic [2:0]                  scroll_dy,
  output logic                        busy
);

  import jump_pkg::*;

  localparam int IW = $clog2(NUM_PLAT);
  localparam logic [10:0] H11   = 11'(SCREEN_H);
  localparam logic [10:0] SPD11 = 11'(SCROLL_SPD);
  localparam logic [9:0]  SPD10 = 10'(SCROLL_SPD);
  localparam logic [9:0]  DST10 = 10'(SCROLL_DIST);
  localparam logic [9:0]  THR10 = 10'(THRESH);
  localparam logic [IW-1:0] LAST = IW'(NUM_PLAT - 1);

  ref_state_t      st;
  plat_t           tbl [NUM_PLAT];
  plat_t           scr [NUM_PLAT];
  logic [10:0]     sum [NUM_PLAT];
  logic [IW-1:0]   idx;
  logic [9:0]      acc;
  logic [9:0]      acc_nx;
  logic [9:0]      seed_y;
  logic [9:0]      new_x;
  logic [15:0]     lfsr;
  logic            menu;
  logic            ovr_load;
  logic            ovr_menu;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .state  (lfsr)
  );

  assign new_x  = lfsr_x(lfsr);
  assign acc_nx = acc + SPD10;
  assign seed_y = 10'(SCREEN_H - 40
                - int'(idx) * PLAT_STEP);

  assign menu     = (outstate == GS_MENU);
  assign ovr_load = loadplat
                  && (st == ST_ARMED
                   || st == ST_SCROLL
                   || st == ST_DONE);
  assign ovr_menu = menu
                  && st != ST_LOAD
                  && st != ST_IDLE;

  assign rd_x = tbl[rd_idx].x;
  assign rd_y = tbl[rd_idx].y;
  assign busy = (st == ST_LOAD)
             || (st == ST_SCROLL);

  // Next table image for one scroll step,
  // recycling anything that falls off-screen.
  always_comb begin
    for (int i = 0; i < NUM_PLAT; i++) begin
      sum[i] = {1'b0, tbl[i].y} + SPD11;
      scr[i] = tbl[i];
      if (sum[i] >= H11) begin
        scr[i].y = 10'(sum[i] - H11);
        scr[i].x = new_x;
      end else begin
        scr[i].y = sum[i][9:0];
      end
    end
  end

  // Control FSM, table writes and registered outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      st         <= ST_IDLE;
      idx        <= '0;
      acc        <= '0;
      refresh_en <= 1'b0;
      trigger    <= 1'b0;
      scroll_dy  <= '0;
      for (int i = 0; i < NUM_PLAT; i++)
        tbl[i] <= '0;
    end else begin
      trigger   <= 1'b0;
      scroll_dy <= '0;
      if (ovr_load) begin
        st         <= ST_LOAD;
        idx        <= '0;
        acc        <= '0;
        refresh_en <= 1'b0;
      end else if (ovr_menu) begin
        st         <= ST_IDLE;
        refresh_en <= 1'b0;
      end else begin
        unique case (st)
          ST_IDLE: begin
            if (loadplat) begin
              st  <= ST_LOAD;
              idx <= '0;
            end
          end
          ST_LOAD: begin
            tbl[idx] <= '{x: new_x, y: seed_y};
            idx      <= idx + 1'b1;
            if (idx == LAST) st <= ST_ARMED;
          end
          ST_ARMED: begin
            if (refresh_en
                && outstate == GS_REFRESH) begin
              refresh_en <= 1'b0;
              acc        <= '0;
              st         <= ST_SCROLL;
            end else if (frame_tick
                && outstate == GS_GAME
                && doodle_y < THR10) begin
              refresh_en <= 1'b1;
            end
          end
          ST_SCROLL: begin
            if (frame_tick) begin
              tbl       <= scr;
              scroll_dy <= 3'(SCROLL_SPD);
              acc       <= acc_nx;
              if (acc_nx == DST10) begin
                st      <= ST_DONE;
                trigger <= 1'b1;
              end
            end
          end
          ST_DONE: st <= ST_ARMED;
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
